// File: rtl/spi_av_pkg.sv
// Shared constants and FSM state type for the SPI-bridge Avalon-MM master sequencer.
package spi_av_pkg;

    localparam int unsigned SPI_WORD_W  = 32;
    localparam logic [7:0]  SPI_TX_ADDR = 8'h00;
    localparam logic [7:0]  SPI_RX_ADDR = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_IRQ,
        ST_READ,
        ST_RESP
    } spi_av_state_t;

endpackage

// File: rtl/spi_av_master.sv
// Runs one SPI word transaction per request on the bridge's Avalon slave:
// write TX word, wait for irq (with timeout), read RX word, return it.
module spi_av_master
    import spi_av_pkg::*;
#(
    parameter logic [7:0]  WR_ADDR = SPI_TX_ADDR,
    parameter logic [7:0]  RD_ADDR = SPI_RX_ADDR,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [SPI_WORD_W-1:0] i_req_data,
    input  logic                  i_req_discard,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [SPI_WORD_W-1:0] o_rsp_data,
    output logic                  o_rsp_timeout,
    output logic [7:0]            o_av_address,
    output logic                  o_av_chip_select,
    output logic                  o_av_write,
    output logic                  o_av_read,
    output logic [SPI_WORD_W-1:0] o_av_write_data,
    input  logic                  i_av_wait_request,
    input  logic [SPI_WORD_W-1:0] i_av_read_data,
    input  logic                  i_irq,
    output logic                  o_busy,
    output logic [15:0]           o_timeout_count
);

    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT - 1);

    spi_av_state_t         r_state;
    spi_av_state_t         w_next_state;
    logic [SPI_WORD_W-1:0] r_tx_data;
    logic [SPI_WORD_W-1:0] r_rsp_data;
    logic                  r_discard;
    logic                  r_rsp_timeout;
    logic [15:0]           r_tmo_cnt;
    logic [15:0]           r_timeout_count;
    logic                  w_accept;
    logic                  w_wr_done;
    logic                  w_rd_done;
    logic                  w_expired;

    assign w_accept  = (r_state == ST_IDLE) && i_req_valid;
    assign w_wr_done = (r_state == ST_WRITE) && !i_av_wait_request;
    assign w_rd_done = (r_state == ST_READ) && !i_av_wait_request;
    // irq has priority over expiry on the cycle the counter reaches zero
    assign w_expired = (r_state == ST_WAIT_IRQ) && !i_irq && (r_tmo_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        o_req_ready      = 1'b0;
        o_rsp_valid      = 1'b0;
        o_av_address     = '0;
        o_av_chip_select = 1'b0;
        o_av_write       = 1'b0;
        o_av_read        = 1'b0;
        o_av_write_data  = '0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                o_av_chip_select = 1'b1;
                o_av_write       = 1'b1;
                o_av_address     = WR_ADDR;
                o_av_write_data  = r_tx_data;
                if (!i_av_wait_request) w_next_state = ST_WAIT_IRQ;
            end
            ST_WAIT_IRQ: begin
                if (i_irq) begin
                    w_next_state = ST_READ;
                end else if (r_tmo_cnt == '0) begin
                    w_next_state = r_discard ? ST_IDLE : ST_RESP;
                end
            end
            ST_READ: begin
                o_av_chip_select = 1'b1;
                o_av_read        = 1'b1;
                o_av_address     = RD_ADDR;
                if (!i_av_wait_request) w_next_state = r_discard ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_data       <= '0;
            r_discard       <= 1'b0;
            r_rsp_data      <= '0;
            r_rsp_timeout   <= 1'b0;
            r_tmo_cnt       <= '0;
            r_timeout_count <= '0;
        end else begin
            if (w_accept) begin
                r_tx_data <= i_req_data;
                r_discard <= i_req_discard;
            end
            if (w_wr_done) begin
                r_tmo_cnt <= TMO_LOAD;
            end else if ((r_state == ST_WAIT_IRQ) && (r_tmo_cnt != '0)) begin
                r_tmo_cnt <= r_tmo_cnt - 16'd1;
            end
            if (w_rd_done) begin
                r_rsp_data    <= i_av_read_data;
                r_rsp_timeout <= 1'b0;
            end else if (w_expired) begin
                r_rsp_data    <= '0;
                r_rsp_timeout <= 1'b1;
                if (r_timeout_count != '1) r_timeout_count <= r_timeout_count + 16'd1;
            end
        end
    end

    assign o_rsp_data      = r_rsp_data;
    assign o_rsp_timeout   = r_rsp_timeout;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_timeout_count = r_timeout_count;

endmodule

// File: tb/tb_spi_av_master.sv
// Directed bench for spi_av_master: transaction-level model checked every cycle
// plus literal latency/data expectations per scenario.
module tb_spi_av_master;

    localparam int          TMO = 16;
    localparam logic [31:0] WRA = 32'h0000_0000;
    localparam logic [31:0] RDA = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_discard = 1'b0, rsp_ready = 1'b1;
    logic        wait_req = 1'b0, irq = 1'b0;
    logic [31:0] req_data = '0, rd_data = '0;
    logic        req_ready, rsp_valid, rsp_timeout, av_cs, av_write, av_read, busy;
    logic [31:0] rsp_data, av_wdata;
    logic [7:0]  av_addr;
    logic [15:0] tcount;

    spi_av_master #(.TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_data(req_data), .i_req_discard(req_discard),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_timeout(rsp_timeout),
        .o_av_address(av_addr), .o_av_chip_select(av_cs),
        .o_av_write(av_write), .o_av_read(av_read),
        .o_av_write_data(av_wdata), .i_av_wait_request(wait_req),
        .i_av_read_data(rd_data), .i_irq(irq),
        .o_busy(busy), .o_timeout_count(tcount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // slave / bridge behaviour knobs
    int   irq_after = 1000, stall = 0, scnt = 0;
    logic irq_force = 1'b0;

    // transaction model
    logic        act = 0, wdone = 0, rdone = 0, tmo = 0, mdisc = 0, prev_rspv = 0;
    logic [31:0] mtx = '0, mrsp = '0, cap_data = '0;
    logic        cap_tmo = 0;
    logic [15:0] m_tcnt = '0;
    int m_wc = 0, rd_start = 0, rsp_cyc = 0, eff = 0;
    int n_acc = 0, n_done = 0, n_wr = 0, n_rd = 0, n_rspr = 0;
    int last_acc = 0, last_wc = 0, last_rsp = 0, last_end = 0, last_hs = 0;

    // Slave: stalls each transfer for 'stall' cycles; irq rises irq_after cycles
    // after write completion and drops once the RX word is read.
    always @(posedge clk) begin
        #1;
        if ((av_write === 1'b1 || av_read === 1'b1) && scnt < stall) begin
            wait_req = 1'b1;
            scnt++;
        end else begin
            wait_req = 1'b0;
            scnt = 0;
        end
        irq = irq_force || (wdone && !rdone && !tmo && cyc >= m_wc + irq_after);
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid === 1'b1 && !prev_rspv) n_rspr++;
        prev_rspv = (rsp_valid === 1'b1);
        if (rst) begin
            act = 0; wdone = 0; rdone = 0; tmo = 0; m_tcnt = '0;
        end else begin
            chkb("busy_vs_ready", busy, !req_ready);
            chkb("chip_select", av_cs, av_write | av_read);
            chk("timeout_count", {16'h0, tcount}, {16'h0, m_tcnt});
            if (!av_write && !av_read) begin
                chk("idle_addr", {24'h0, av_addr}, 0);
                chk("idle_wdata", av_wdata, 0);
            end
            if (!act) begin
                chkb("idle_ready", req_ready, 1'b1);
                chkb("idle_rspv", rsp_valid, 1'b0);
                chkb("idle_wr", av_write, 1'b0);
                chkb("idle_rd", av_read, 1'b0);
                if (req_valid) begin
                    act = 1; wdone = 0; rdone = 0; tmo = 0;
                    mtx = req_data; mdisc = req_discard;
                    last_acc = cyc; n_acc++;
                end
            end else if (!wdone) begin
                chkb("wr_strobe", av_write, 1'b1);
                chk("wr_addr", {24'h0, av_addr}, WRA);
                chk("wr_data", av_wdata, mtx);
                chkb("wr_nord", av_read, 1'b0);
                chkb("wr_ready", req_ready, 1'b0);
                chkb("wr_rspv", rsp_valid, 1'b0);
                if (!wait_req) begin
                    wdone = 1; m_wc = cyc; last_wc = cyc; n_wr++;
                    eff = irq_force ? 1 : irq_after;
                    // irq is honoured on any of the TMO cycles after the write
                    if (eff <= TMO) begin
                        rd_start = cyc + eff + 1;
                        mrsp = rd_data;
                    end else begin
                        tmo = 1;
                        rsp_cyc = cyc + TMO + 1;
                        mrsp = '0;
                    end
                end
            end else if (!tmo && !rdone) begin
                chkb("wt_ready", req_ready, 1'b0);
                chkb("wt_rspv", rsp_valid, 1'b0);
                chkb("wt_nowr", av_write, 1'b0);
                if (cyc < rd_start) begin
                    chkb("wt_nord", av_read, 1'b0);
                end else begin
                    chkb("rd_strobe", av_read, 1'b1);
                    chk("rd_addr", {24'h0, av_addr}, RDA);
                    chk("rd_wdata", av_wdata, 0);
                    if (!wait_req) begin
                        rdone = 1; n_rd++; rsp_cyc = cyc + 1;
                        if (mdisc) begin act = 0; n_done++; last_end = cyc + 1; end
                    end
                end
            end else if (cyc < rsp_cyc) begin
                chkb("tw_ready", req_ready, 1'b0);
                chkb("tw_rspv", rsp_valid, 1'b0);
                chkb("tw_nowr", av_write, 1'b0);
                chkb("tw_nord", av_read, 1'b0);
                if (cyc == rsp_cyc - 1) begin
                    if (m_tcnt != 16'hFFFF) m_tcnt++;
                    if (mdisc) begin act = 0; n_done++; last_end = cyc + 1; end
                end
            end else begin
                chkb("rsp_valid", rsp_valid, 1'b1);
                chk("rsp_data", rsp_data, mrsp);
                chkb("rsp_timeout", rsp_timeout, tmo);
                chkb("rsp_ready_out", req_ready, 1'b0);
                chkb("rsp_nowr", av_write, 1'b0);
                chkb("rsp_nord", av_read, 1'b0);
                if (cyc == rsp_cyc) begin
                    last_rsp = cyc; cap_data = rsp_data; cap_tmo = rsp_timeout;
                end
                if (rsp_ready) begin act = 0; n_done++; last_hs = cyc; last_end = cyc + 1; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [31:0] d, input logic disc);
        int n0;
        n0 = n_acc;
        req_valid = 1'b1; req_data = d; req_discard = disc;
        for (int i = 0; i < 400 && n_acc == n0; i++) tick();
        req_valid = 1'b0;
        chk("accept_bound", n_acc - n0, 1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 400 && n_done < target; i++) tick();
        chkb("done_bound", n_done >= target, 1'b1);
    endtask

    task automatic xact(input string nm, input logic [31:0] d, input logic disc, input int ia,
                        input int st, input logic [31:0] rv, input int exp_lat);
        int d0, w0, p0;
        d0 = n_done; w0 = n_wr; p0 = n_rspr;
        irq_after = ia; stall = st; rd_data = rv;
        start_req(d, disc);
        wait_done(d0 + 1);
        chk({nm, "_writes"}, n_wr - w0, 1);
        chk({nm, "_rsps"}, n_rspr - p0, disc ? 0 : 1);
        if (exp_lat >= 0) chk({nm, "_latency"}, (disc ? last_end : last_rsp) - last_acc, exp_lat);
    endtask

    task automatic chk_reset_state(input string nm);
        chkb({nm, "_ready"}, req_ready, 1'b1);
        chkb({nm, "_rspv"}, rsp_valid, 1'b0);
        chk({nm, "_rdata"}, rsp_data, 0);
        chkb({nm, "_rtmo"}, rsp_timeout, 1'b0);
        chk({nm, "_bus"}, {av_addr, 5'b0, av_cs, av_write, av_read, 16'h0}, 0);
        chk({nm, "_wdata"}, av_wdata, 0);
        chkb({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_tcnt"}, {16'h0, tcount}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r0, a0, d0, p0, hs0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");
        tick();

        // zero-wait slave, irq 5 cycles after write: accept->rsp = 8 cycles
        r0 = n_rd;
        xact("zw", 32'hA5A5_0001, 1'b0, 5, 0, 32'h1234_5678, 8);
        chk("zw_data", cap_data, 32'h1234_5678);
        chkb("zw_tmo", cap_tmo, 1'b0);
        chk("zw_reads", n_rd - r0, 1);

        // back-to-back, minimum latency
        hs0 = last_hs;
        xact("b2b", 32'h0000_0002, 1'b0, 1, 0, 32'hDEAD_0002, 4);
        chk("b2b_gap", last_acc - hs0, 1);

        // 3-cycle stall on write and read
        r0 = n_rd;
        xact("stall", 32'h3C3C_0003, 1'b0, 2, 3, 32'h0BAD_F00D, 11);
        chk("stall_reads", n_rd - r0, 1);
        chk("stall_data", cap_data, 32'h0BAD_F00D);

        // irq never arrives
        r0 = n_rd;
        xact("tmo", 32'h1111_0004, 1'b0, 1000, 0, 32'hFFFF_FFFF, -1);
        chk("tmo_gap", last_rsp - last_wc, 17);
        chk("tmo_data", cap_data, 0);
        chkb("tmo_flag", cap_tmo, 1'b1);
        chk("tmo_count", {16'h0, tcount}, 1);
        chk("tmo_reads", n_rd - r0, 0);

        // irq on the counter-zero cycle wins
        xact("edge16", 32'h1111_0005, 1'b0, 16, 0, 32'h5555_AAAA, -1);
        chk("edge16_gap", last_rsp - last_wc, 18);
        chkb("edge16_flag", cap_tmo, 1'b0);
        chk("edge16_data", cap_data, 32'h5555_AAAA);

        // irq one cycle too late
        xact("edge17", 32'h1111_0006, 1'b0, 17, 0, 32'h6666_BBBB, -1);
        chk("edge17_gap", last_rsp - last_wc, 17);
        chkb("edge17_flag", cap_tmo, 1'b1);
        chk("edge17_count", {16'h0, tcount}, 2);

        // discard: read happens, no response, ready right after read
        r0 = n_rd;
        xact("disc", 32'h2222_0008, 1'b1, 1, 0, 32'h7777_7777, 4);
        chk("disc_reads", n_rd - r0, 1);
        chkb("disc_ready", req_ready, 1'b1);

        // stale irq at accept must not skip the write
        irq_force = 1'b1;
        repeat (3) tick();
        xact("stale", 32'h3333_0009, 1'b0, 1000, 0, 32'h1357_9BDF, 4);
        chk("stale_data", cap_data, 32'h1357_9BDF);
        irq_force = 1'b0;
        tick();

        // consumer stalls 10 cycles with a second request waiting
        a0 = n_acc; d0 = n_done;
        rsp_ready = 1'b0; irq_after = 1; stall = 0; rd_data = 32'hCAFE_000A;
        start_req(32'h4444_000A, 1'b0);
        for (int i = 0; i < 50 && rsp_valid !== 1'b1; i++) tick();
        chkb("hold_seen", rsp_valid, 1'b1);
        req_valid = 1'b1; req_data = 32'h5555_000B; req_discard = 1'b0;
        repeat (10) tick();
        chk("hold_noacc", n_acc - a0, 1);
        chkb("hold_rspv", rsp_valid, 1'b1);
        chk("hold_data", rsp_data, 32'hCAFE_000A);
        chkb("hold_tmo", rsp_timeout, 1'b0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && n_acc != a0 + 2; i++) tick();
        req_valid = 1'b0;
        chk("hold_acc", n_acc - a0, 2);
        chk("hold_gap", last_acc - last_hs, 1);
        wait_done(d0 + 2);

        // reset during a stalled write
        stall = 20; irq_after = 1;
        p0 = n_rspr;
        start_req(32'h6666_000C, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall = 0;
        @(negedge clk);
        chk_reset_state("midrst");
        repeat (30) tick();
        chk("midrst_norsp", n_rspr - p0, 0);

        xact("post", 32'h7777_000D, 1'b0, 3, 0, 32'h0F0F_F0F0, 6);
        chk("post_data", cap_data, 32'h0F0F_F0F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_av_master.md
# spi_av_master

Avalon-MM master sequencer that drives the SPI bridge's Avalon slave port and runs one full-duplex SPI word transaction per request: write the TX word, wait for the bridge `irq`, then read the RX word. It sits directly upstream of the SPI Avalon bridge on the 120 MHz domain. It turns a valid/ready request stream into bus cycles and returns RX words on a valid/ready response stream, with timeout protection.

## Interface
- `WR_ADDR`, 8'h00: Avalon address of the bridge TX data register.
- `RD_ADDR`, 8'h04: Avalon address of the bridge RX data register.
- `TIMEOUT`, 4096: cycles to wait for `irq` after the write completes; legal range 2..65535.

Ports:
- `clk` in 1: system clock (120 MHz domain); all logic runs on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_data` in 32: TX word.
- `req_discard` in 1: run the transaction but drop the RX word (no response).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out 32: RX word; 0 on timeout.
- `rsp_timeout` out 1: response produced by timeout.
- `av_address` out 8: bus address.
- `av_chip_select` out 1: bus select.
- `av_write` out 1: bus write strobe.
- `av_read` out 1: bus read strobe.
- `av_write_data` out 32: bus write data.
- `av_wait_request` in 1: slave stall.
- `av_read_data` in 32: slave read data.
- `irq` in 1: level-high RX data available from the bridge.
- `busy` out 1: FSM not in IDLE.
- `timeout_count` out 16: saturating count of timeouts since reset.

## Operation
- FSM states: IDLE, WRITE, WAIT_IRQ, READ, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, latch `req_data` and `req_discard`, then go to WRITE.
- WRITE
  - Drive `av_chip_select`=1, `av_write`=1, `av_address`=WR_ADDR, `av_write_data`=latched word.
  - Hold all bus outputs stable while `av_wait_request`=1.
  - The transfer completes on the cycle where `av_wait_request`=0. On completion, load the timeout counter with TIMEOUT-1 and go to WAIT_IRQ.
- WAIT_IRQ
  - Bus idle.
  - `irq`=1 → READ.
  - Otherwise, if the counter is 0 → set timeout result, increment `timeout_count` (saturating at 16'hFFFF), and go to RESP, or to IDLE if discard.
  - Otherwise decrement the counter.
  - If `irq` is 1 on the same cycle the counter reaches 0, `irq` wins.
- READ
  - Drive `av_chip_select`=1, `av_read`=1, `av_address`=RD_ADDR.
  - On the cycle with `av_wait_request`=0, capture `av_read_data` (zero read latency).
  - Then go to RESP, or to IDLE if discard.
- RESP
  - `rsp_valid`=1; `rsp_data` and `rsp_timeout` are held stable until `rsp_ready`=1.
  - On the handshake cycle go to IDLE.
  - `req_ready` stays 0 while in RESP.
- `irq` is ignored outside WAIT_IRQ. A stale `irq` present at request accept does not shortcut the write.
- `av_write_data` is 0 and `av_address` is 0 whenever no bus strobe is asserted.

## Timing
- Reset values: state IDLE; `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_timeout`=0, all `av_*` outputs 0, `busy`=0, `timeout_count`=0.
- Reset mid-transaction: bus strobes drop on the next edge, the transaction is abandoned, and no response is produced.
- Zero-wait-state latency:
  - Accept at cycle 0; write strobe in cycle 1.
  - WAIT_IRQ starts at cycle 2. If `irq` is sampled high in cycle k, the read strobe is in cycle k+1 and `rsp_valid` rises in cycle k+2.
  - Minimum accept-to-`rsp_valid` is 4 cycles.
- Timeout: `rsp_valid` rises exactly TIMEOUT+1 cycles after the write-completion cycle when `irq` stays low.
- Back-to-back throughput: with `rsp_ready` tied high, the next accept is possible on the cycle after the RESP handshake.

## Structure
- Shared package `spi_av_pkg`:
  - FSM state enum.
  - Default register addresses (`SPI_TX_ADDR`, `SPI_RX_ADDR`).
  - `SPI_WORD_W`=32.
- No sub-module needed. The timeout counter and the saturating error counter are inline registers.

## Test plan
- Zero-wait slave: `req_data`=32'hA5A5_0001, `irq` asserted 5 cycles after the write → one write at 8'h00 with 32'hA5A5_0001, one read at 8'h04; slave returns 32'h1234_5678 → `rsp_data`=32'h1234_5678, `rsp_timeout`=0.
- Slave holds `av_wait_request` for 3 cycles on both write and read → address, data and strobes stable throughout the stall; exactly one write and one read complete.
- TIMEOUT=16, `irq` never asserted → `rsp_valid` 17 cycles after write completion, `rsp_data`=0, `rsp_timeout`=1, `timeout_count`=1. In a second run, `irq` rises on the same cycle the counter hits 0 → read performed, `rsp_timeout`=0.
- `req_discard`=1 → the read still occurs, `rsp_valid` never asserts, and `req_ready` returns 1 the cycle after read completion.
- `rsp_ready` held low 10 cycles → `rsp_valid`, `rsp_data` and `rsp_timeout` stable; `req_valid` not accepted until the handshake.
- `reset` pulsed during a stalled WRITE → next cycle all `av_*` outputs are 0, `req_ready`=1, `rsp_valid`=0, and no response is ever emitted for that request.
